// File: rtl/spike_aer_pkg.sv
// -----------------------------------------------------------------------------
// spike_aer_pkg
// Shared types and elaboration-time helpers for the spike AER encoder.
//   state_t       : encoder FSM states
//   words_f       : number of packed input words per frame, ceil(N/PW)
//   last_mask_f   : valid-bit mask for the final word of a frame (up to 64 bits)
//   idx_width_f   : word index width, ceil_log2(WORDS) with a minimum of 1
// -----------------------------------------------------------------------------
package spike_aer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SCAN,
    S_DONE
  } state_t;

  // Widest packed word the mask helper can describe.
  localparam int MAX_PACK_WIDTH = 64;

  function automatic int words_f(input int n, input int pw);
    return (n + pw - 1) / pw;
  endfunction

  function automatic int idx_width_f(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Low (N - (WORDS-1)*PW) bits set; the caller slices it to PACK_WIDTH bits.
  function automatic logic [MAX_PACK_WIDTH-1:0] last_mask_f(input int n, input int pw);
    logic [MAX_PACK_WIDTH-1:0] m;
    int bits;
    m    = '0;
    bits = n - (words_f(n, pw) - 1) * pw;
    for (int k = 0; k < MAX_PACK_WIDTH; k++) begin
      if (k < bits) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// -----------------------------------------------------------------------------
// lsb_prio_enc
// Combinational lowest-set-bit priority encoder.
//   vec     : input vector (W bits)
//   idx     : index of the lowest set bit (0 when vec is zero)
//   any     : vec has at least one bit set
//   one_hot : vec has exactly one bit set
// -----------------------------------------------------------------------------
module lsb_prio_enc #(
  parameter int W = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          one_hot
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (vec[k]) idx = IW'(k);
    end
  end

  assign any = |vec;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign one_hot = any && ((vec & (vec - W'(1))) == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// -----------------------------------------------------------------------------
// spike_aer_encoder
// Converts a frame of packed spike words (neuron order, starting at neuron 0)
// into address events, one per cycle, for the synapse/router fabric.
//   clk, rst        : clock, synchronous active-high reset
//   i_start         : begin a frame (only honoured while idle)
//   o_done          : one-cycle pulse after the frame's last event
//   i_spike_valid / i_spike_data / o_spike_ready : packed spike word input
//   o_aer_valid / o_aer_addr / o_aer_last / i_aer_ready : event output
//   o_frame_count   : events handshaken this frame (only with SPIKE_AER_COUNT_EN)
// Optional feature macro: SPIKE_AER_COUNT_EN (event counter and its port).
// All outputs are registered.
// -----------------------------------------------------------------------------
module spike_aer_encoder
  import spike_aer_pkg::*;
#(
  parameter int N          = 4096,
  parameter int ADDRW      = 12,
  parameter int PACK_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_done,
  input  logic                  i_spike_valid,
  input  logic [PACK_WIDTH-1:0] i_spike_data,
  output logic                  o_spike_ready,
  output logic                  o_aer_valid,
  output logic [ADDRW-1:0]      o_aer_addr,
  output logic                  o_aer_last,
  input  logic                  i_aer_ready
`ifdef SPIKE_AER_COUNT_EN
  ,
  output logic [ADDRW:0]        o_frame_count
`endif
);

  localparam int WORDS = words_f(N, PACK_WIDTH);
  localparam int WIW   = idx_width_f(WORDS);
  localparam int SHIFT = $clog2(PACK_WIDTH);
  localparam int IW    = SHIFT;
  localparam logic [WIW-1:0] LAST_IDX = WIW'(WORDS - 1);
  localparam logic [MAX_PACK_WIDTH-1:0] LAST_MASK_FULL = last_mask_f(N, PACK_WIDTH);
  localparam logic [PACK_WIDTH-1:0] LAST_MASK = LAST_MASK_FULL[PACK_WIDTH-1:0];

  state_t                  state_reg, state_next;
  logic [WIW-1:0]          word_idx_reg, word_idx_next;
  logic [PACK_WIDTH-1:0]   buf_reg, buf_next;
  logic [ADDRW-1:0]        base_reg, base_next;
  logic                    spike_ready_reg, spike_ready_next;
  logic                    aer_valid_reg, aer_valid_next;
  logic [ADDRW-1:0]        aer_addr_reg, aer_addr_next;
  logic                    aer_last_reg, aer_last_next;
  logic                    done_reg, done_next;

  logic                    is_last_word;
  logic [PACK_WIDTH-1:0]   in_word;
  logic [IW-1:0]           enc_idx;
  logic                    enc_any;
  logic                    enc_one_hot;

  // The encoder looks at the buffer as it will be after this edge, so the
  // registered event outputs already describe the next pending bit. This
  // gives one event per cycle with registered outputs and no bubble.
  lsb_prio_enc #(.W(PACK_WIDTH)) u_enc (
    .vec     (buf_next),
    .idx     (enc_idx),
    .any     (enc_any),
    .one_hot (enc_one_hot)
  );

  assign is_last_word = (word_idx_reg == LAST_IDX);
  assign in_word      = is_last_word ? (i_spike_data & LAST_MASK) : i_spike_data;

  always_comb begin
    state_next       = state_reg;
    word_idx_next    = word_idx_reg;
    buf_next         = buf_reg;
    base_next        = base_reg;
    spike_ready_next = spike_ready_reg;
    done_next        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          word_idx_next    = '0;
          state_next       = S_RECV;
          spike_ready_next = 1'b1;
        end
      end
      S_RECV: begin
        if (i_spike_valid && spike_ready_reg) begin
          buf_next         = in_word;
          base_next        = ADDRW'(word_idx_reg) << SHIFT;
          spike_ready_next = 1'b0;
          state_next       = S_SCAN;
        end
      end
      S_SCAN: begin
        // Handshake retires the lowest set bit: x & (x-1).
        if (aer_valid_reg && i_aer_ready) begin
          buf_next = buf_reg & (buf_reg - PACK_WIDTH'(1));
        end
        if (buf_next == '0) begin
          if (is_last_word) begin
            state_next = S_DONE;
            done_next  = 1'b1;
          end else begin
            word_idx_next    = word_idx_reg + WIW'(1);
            state_next       = S_RECV;
            spike_ready_next = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    aer_valid_next = (state_next == S_SCAN) && enc_any;
    aer_addr_next  = aer_valid_next ? (base_next + ADDRW'(enc_idx)) : '0;
    aer_last_next  = aer_valid_next && is_last_word && enc_one_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      word_idx_reg    <= '0;
      buf_reg         <= '0;
      base_reg        <= '0;
      spike_ready_reg <= 1'b0;
      aer_valid_reg   <= 1'b0;
      aer_addr_reg    <= '0;
      aer_last_reg    <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      word_idx_reg    <= word_idx_next;
      buf_reg         <= buf_next;
      base_reg        <= base_next;
      spike_ready_reg <= spike_ready_next;
      aer_valid_reg   <= aer_valid_next;
      aer_addr_reg    <= aer_addr_next;
      aer_last_reg    <= aer_last_next;
      done_reg        <= done_next;
    end
  end

  assign o_done        = done_reg;
  assign o_spike_ready = spike_ready_reg;
  assign o_aer_valid   = aer_valid_reg;
  assign o_aer_addr    = aer_addr_reg;
  assign o_aer_last    = aer_last_reg;

`ifdef SPIKE_AER_COUNT_EN
  localparam logic [ADDRW:0] COUNT_MAX = (ADDRW + 1)'(N);

  logic [ADDRW:0] count_reg;

  // Holds after the frame ends; only a new accepted start clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (state_reg == S_IDLE && i_start) begin
      count_reg <= '0;
    end else if (aer_valid_reg && i_aer_ready && count_reg != COUNT_MAX) begin
      count_reg <= count_reg + (ADDRW + 1)'(1);
    end
  end

  assign o_frame_count = count_reg;
`endif

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

  localparam int N     = 20;
  localparam int ADDRW = 5;
  localparam int PW    = 8;
  localparam int LAST_BASE = 16;  // first neuron of the final word

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_spike_valid = 1'b0;
  logic [PW-1:0]    i_spike_data = '0;
  logic             i_aer_ready = 1'b0;
  logic             o_done;
  logic             o_spike_ready;
  logic             o_aer_valid;
  logic [ADDRW-1:0] o_aer_addr;
  logic             o_aer_last;
`ifdef SPIKE_AER_COUNT_EN
  logic [ADDRW:0]   o_frame_count;
`endif

  spike_aer_encoder #(.N(N), .ADDRW(ADDRW), .PACK_WIDTH(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .o_done        (o_done),
    .i_spike_valid (i_spike_valid),
    .i_spike_data  (i_spike_data),
    .o_spike_ready (o_spike_ready),
    .o_aer_valid   (o_aer_valid),
    .o_aer_addr    (o_aer_addr),
    .o_aer_last    (o_aer_last),
    .i_aer_ready   (i_aer_ready)
`ifdef SPIKE_AER_COUNT_EN
    ,
    .o_frame_count (o_frame_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int ev_addr[$];
  int ev_last[$];
  int exp_q[$];
  int done_cnt = 0;
  bit rdy_rand = 1'b0;

  int hold_pend = 0;
  int hold_addr = 0;
  int hold_last = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Random consumer backpressure.
  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      i_aer_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Event/done collector plus stability check while stalled.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 0;
    end else begin
      if (hold_pend != 0) begin
        chk("hold_valid", int'(o_aer_valid), 1);
        chk("hold_addr", int'(o_aer_addr), hold_addr);
        chk("hold_last", int'(o_aer_last), hold_last);
      end
      hold_pend = (o_aer_valid && !i_aer_ready) ? 1 : 0;
      hold_addr = int'(o_aer_addr);
      hold_last = int'(o_aer_last);
      if (o_aer_valid && i_aer_ready) begin
        ev_addr.push_back(int'(o_aer_addr));
        ev_last.push_back(int'(o_aer_last));
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    ev_addr.delete();
    ev_last.delete();
    done_cnt = 0;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_word(input logic [PW-1:0] d);
    int n;
    n = 0;
    i_spike_valid = 1'b1;
    i_spike_data  = d;
    while (!o_spike_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("spike_ready_timeout", 0, 1);
    tick();
    i_spike_valid = 1'b0;
    i_spike_data  = '0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      tick();
      n++;
    end
    if (n >= 600) chk("done_timeout", 0, 1);
    tick();
    tick();
  endtask

  // Reference: every neuron index below N whose bit is set, in order.
  task automatic build_model(input logic [PW-1:0] w0, input logic [PW-1:0] w1,
                             input logic [PW-1:0] w2);
    logic [PW-1:0] w [3];
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      if (w[i / PW][i % PW]) exp_q.push_back(i);
    end
  endtask

  task automatic check_events(input string tag);
    int n_last;
    int exp_last;
    chk({tag, "_ev_count"}, ev_addr.size(), exp_q.size());
    chk({tag, "_done_count"}, done_cnt, 1);
    n_last = 0;
    for (int k = 0; k < ev_addr.size() && k < exp_q.size(); k++) begin
      exp_last = (k == exp_q.size() - 1 && exp_q[k] >= LAST_BASE) ? 1 : 0;
      chk({tag, "_addr"}, ev_addr[k], exp_q[k]);
      chk({tag, "_last"}, ev_last[k], exp_last);
    end
    for (int k = 0; k < ev_last.size(); k++) n_last += ev_last[k];
    chk({tag, "_last_count"}, n_last,
        (exp_q.size() > 0 && exp_q[exp_q.size() - 1] >= LAST_BASE) ? 1 : 0);
  endtask

  task automatic run_frame(input string tag, input logic [PW-1:0] w0,
                           input logic [PW-1:0] w1, input logic [PW-1:0] w2);
    clear_obs();
    build_model(w0, w1, w2);
    start_frame();
`ifdef SPIKE_AER_COUNT_EN
    chk({tag, "_count_clear"}, int'(o_frame_count), 0);
`endif
    send_word(w0);
    send_word(w1);
    send_word(w2);
    wait_done();
    check_events(tag);
`ifdef SPIKE_AER_COUNT_EN
    chk({tag, "_frame_count"}, int'(o_frame_count), exp_q.size());
`endif
    $display("frame %s words=%02h %02h %02h events=%0d done=%0d",
             tag, w0, w1, w2, ev_addr.size(), done_cnt);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_done"}, int'(o_done), 0);
    chk({tag, "_spike_ready"}, int'(o_spike_ready), 0);
    chk({tag, "_aer_valid"}, int'(o_aer_valid), 0);
    chk({tag, "_aer_addr"}, int'(o_aer_addr), 0);
    chk({tag, "_aer_last"}, int'(o_aer_last), 0);
  endtask

  typedef struct {
    logic [PW-1:0] w0;
    logic [PW-1:0] w1;
    logic [PW-1:0] w2;
    int            n_events;
    int            last_addr;  // -1: no event carries o_aer_last
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{8'h05, 8'h00, 8'h01, 3, 16};
    tbl[1] = '{8'h00, 8'h00, 8'hFF, 4, 19};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 0, -1};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 20, 19};
    tbl[4] = '{8'h80, 8'h01, 8'h00, 2, -1};
    tbl[5] = '{8'h00, 8'hFF, 8'h00, 8, -1};

    // Reset state.
    rst = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset");
`ifdef SPIKE_AER_COUNT_EN
    chk("reset_frame_count", int'(o_frame_count), 0);
`endif

    // Table-driven frames with the consumer always ready.
    i_aer_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      run_frame($sformatf("tbl%0d", t), tbl[t].w0, tbl[t].w1, tbl[t].w2);
      chk($sformatf("tbl%0d_n_events", t), ev_addr.size(), tbl[t].n_events);
      if (tbl[t].last_addr >= 0 && ev_addr.size() > 0)
        chk($sformatf("tbl%0d_last_addr", t), ev_addr[ev_addr.size() - 1], tbl[t].last_addr);
    end

    // Stalled consumer: 8'h81 holds addr 0 for 5 cycles, then 7 follows.
    clear_obs();
    build_model(8'h81, 8'h00, 8'h00);
    i_aer_ready = 1'b0;
    start_frame();
    send_word(8'h81);
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", int'(o_aer_valid), 1);
      chk("stall_addr", int'(o_aer_addr), 0);
      chk("stall_spike_ready", int'(o_spike_ready), 0);
      tick();
    end
    i_aer_ready = 1'b1;
    tick();
    chk("stall_next_valid", int'(o_aer_valid), 1);
    chk("stall_next_addr", int'(o_aer_addr), 7);
    chk("stall_next_spike_ready", int'(o_spike_ready), 0);
    send_word(8'h00);
    send_word(8'h00);
    wait_done();
    check_events("stall");
    $display("frame stall words=81 00 00 events=%0d done=%0d", ev_addr.size(), done_cnt);

    // Reset in the middle of scanning 8'hF0, after its first event.
    clear_obs();
    start_frame();
    send_word(8'hF0);
    chk("midrst_first_addr", int'(o_aer_addr), 4);
    tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("midrst");
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_events", ev_addr.size(), 1);
    chk("midrst_no_done", done_cnt, 0);
    $display("frame midrst words=f0 events=%0d done=%0d", ev_addr.size(), done_cnt);
    run_frame("after_rst", 8'h02, 8'h00, 8'h00);

    // Randomized frames with random backpressure.
    rdy_rand = 1'b1;
    for (int r = 0; r < 30; r++) begin
      logic [PW-1:0] a, b, c;
      a = ($urandom_range(0, 2) == 0) ? 8'h00 : PW'($urandom);
      b = ($urandom_range(0, 2) == 0) ? 8'h00 : PW'($urandom);
      c = ($urandom_range(0, 2) == 0) ? 8'h00 : PW'($urandom);
      run_frame($sformatf("rnd%0d", r), a, b, c);
    end
    rdy_rand = 1'b0;
    tick();
    i_aer_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
